ball_ctrl: RTL and testbench

Ball motion and collision engine for the Pong display pipeline. It sits directly downstream of the paddle block and consumes its paddle bounding boxes and the VGA pixel coordinates. It moves the ball once per frame, bounces it off the top/bottom walls and both paddles, and detects misses. It produces the ball pixel-enable for the pixel mux and one-cycle miss pulses for the score logic.

---
 rtl/ball_ctrl.sv | 147 ++++++++++++++
 tb/tb_ball_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// Pong ball motion/collision engine: once-per-frame movement, wall and paddle bounces, miss detection.
// Optional feature macro: BALL_SPEEDUP_EN (paddle hits raise speed, saturating at 4).
module ball_ctrl #(
    parameter int unsigned X_MAX        = 639,
    parameter int unsigned Y_MAX        = 479,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned BALL_VEL     = 2,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] pad1_t,
    input  logic [9:0] pad1_b,
    input  logic [9:0] pad1_l,
    input  logic [9:0] pad1_r,
    input  logic [9:0] pad2_t,
    input  logic [9:0] pad2_b,
    input  logic [9:0] pad2_l,
    input  logic [9:0] pad2_r,
    output logic       ball_on,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       miss1,
    output logic       miss2,
    output logic       serving
);

    localparam int unsigned CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [9:0]  CENTRE_X = 10'd316;
    localparam logic [9:0]  CENTRE_Y = 10'd236;
    localparam logic [2:0]  VEL      = 3'(BALL_VEL);

    typedef enum logic [1:0] {SERVE, PLAY, MISS} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dx;
    logic          dy;
    logic [2:0]    spd;

    logic          tick;
    logic [10:0]   bl, br, bt, bb, sp;
    logic          hit_r, hit_l, miss_r, miss_l, wall_t, wall_b;
    logic          dx_n, dy_n;
    logic [9:0]    nx, ny;

    // Edge arithmetic carried in 11 bits so paddle sums near the top of range cannot wrap.
    always_comb begin
        tick   = (y == 10'd481) && (x == '0);
        sp     = {8'd0, spd};
        bl     = {1'b0, ball_x};
        br     = bl + 11'(BALL_SIZE - 1);
        bt     = {1'b0, ball_y};
        bb     = bt + 11'(BALL_SIZE - 1);

        hit_r  = dx && (br >= {1'b0, pad1_l}) && (br <= {1'b0, pad1_r} + sp)
                    && (bb >= {1'b0, pad1_t}) && (bt <= {1'b0, pad1_b});
        hit_l  = !dx && (bl <= {1'b0, pad2_r}) && (bl + sp >= {1'b0, pad2_l})
                    && (bb >= {1'b0, pad2_t}) && (bt <= {1'b0, pad2_b});
        miss_r = dx && (br >= 11'(X_MAX) - sp);
        miss_l = !dx && (bl <= sp);
        wall_t = (bt <= sp);
        wall_b = (bb >= 11'(Y_MAX) - sp);

        dx_n   = hit_r ? 1'b0 : (hit_l ? 1'b1 : dx);
        dy_n   = wall_t ? 1'b1 : (wall_b ? 1'b0 : dy);
        nx     = dx_n ? ball_x + 10'(spd) : ball_x - 10'(spd);
        ny     = dy_n ? ball_y + 10'(spd) : ball_y - 10'(spd);

        ball_on = (bl <= {1'b0, x}) && ({1'b0, x} <= br)
               && (bt <= {1'b0, y}) && ({1'b0, y} <= bb);
    end

`ifndef BALL_SPEEDUP_EN
    assign spd = VEL;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SERVE;
            cnt     <= '0;
            ball_x  <= CENTRE_X;
            ball_y  <= CENTRE_Y;
            dx      <= 1'b0;
            dy      <= 1'b1;
            miss1   <= 1'b0;
            miss2   <= 1'b0;
            serving <= 1'b1;
`ifdef BALL_SPEEDUP_EN
            spd     <= VEL;
`endif
        end else begin
            miss1 <= 1'b0;
            miss2 <= 1'b0;
            if (tick) begin
                case (state)
                    SERVE: begin
                        ball_x <= CENTRE_X;
                        ball_y <= CENTRE_Y;
                        if (cnt == CW'(SERVE_FRAMES - 1)) begin
                            cnt     <= '0;
                            state   <= PLAY;
                            serving <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PLAY: begin
                        dy <= dy_n;
                        // A paddle hit outranks a miss detected in the same frame.
                        if (!(hit_r || hit_l) && miss_r) begin
                            miss1 <= 1'b1;
                            dx    <= 1'b1;
                            state <= MISS;
                        end else if (!(hit_r || hit_l) && miss_l) begin
                            miss2 <= 1'b1;
                            dx    <= 1'b0;
                            state <= MISS;
                        end else begin
                            dx     <= dx_n;
                            ball_x <= nx;
                            ball_y <= ny;
`ifdef BALL_SPEEDUP_EN
                            if (hit_r || hit_l)
                                spd <= (spd >= 3'd4) ? 3'd4 : spd + 3'd1;
`endif
                        end
                    end
                    MISS: begin
                        state   <= SERVE;
                        serving <= 1'b1;
                        cnt     <= '0;
                        ball_x  <= CENTRE_X;
                        ball_y  <= CENTRE_Y;
`ifdef BALL_SPEEDUP_EN
                        spd     <= VEL;
`endif
                    end
                    default: state <= SERVE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl (default build): reset, ball_on table, serve, left/right miss,
// paddle and wall bounces along hand-derived trajectories, and asynchronous reset mid-rally.
module tb_ball_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic [9:0] pad1_t, pad1_b, pad1_l, pad1_r;
    logic [9:0] pad2_t, pad2_b, pad2_l, pad2_r;
    logic       ball_on, miss1, miss2, serving;
    logic [9:0] ball_x, ball_y;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       on;
    } vec_t;
    vec_t tbl[10];

    ball_ctrl #(
        .X_MAX(639), .Y_MAX(479), .BALL_SIZE(8), .BALL_VEL(2), .SERVE_FRAMES(60)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .pad1_t(pad1_t), .pad1_b(pad1_b), .pad1_l(pad1_l), .pad1_r(pad1_r),
        .pad2_t(pad2_t), .pad2_b(pad2_b), .pad2_l(pad2_l), .pad2_r(pad2_r),
        .ball_on(ball_on), .ball_x(ball_x), .ball_y(ball_y),
        .miss1(miss1), .miss2(miss2), .serving(serving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        x = 10'd0;
        y = 10'd481;
        @(posedge clk);
        #1;
        y = 10'd0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic pads_far();
        pad1_t = 10'd1000; pad1_b = 10'd1010; pad1_l = 10'd1000; pad1_r = 10'd1010;
        pad2_t = 10'd1000; pad2_b = 10'd1010; pad2_l = 10'd1000; pad2_r = 10'd1010;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, ball_x, 316);
        chk({tag, "_y"}, ball_y, 236);
        chk({tag, "_serving"}, serving, 1);
        chk({tag, "_miss1"}, miss1, 0);
        chk({tag, "_miss2"}, miss2, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b1;
    endtask

    task automatic serve();
        repeat (59) tick();
        chk("serve_hold", serving, 1);
        tick();
        chk("serve_done", serving, 0);
        chk("serve_x", ball_x, 316);
        chk("serve_y", ball_y, 236);
    endtask

    // Trajectory A: no paddles, leftward, bottom wall after 117 moves.
    function automatic int a_x(input int k); return 316 - 2*k; endfunction
    function automatic int a_y(input int k); return (k <= 117) ? 236 + 2*k : 704 - 2*k; endfunction

    // Trajectory B: left paddle bounce at move 8 and 300, right paddle at 154, top wall at 352.
    function automatic int b_x(input int k);
        if (k <= 7)        return 316 - 2*k;
        else if (k <= 153) return 288 + 2*k;
        else if (k <= 299) return 900 - 2*k;
        else               return 2*k - 296;
    endfunction
    function automatic int b_y(input int k);
        if (k <= 117)      return 236 + 2*k;
        else if (k <= 351) return 704 - 2*k;
        else               return 2*k - 700;
    endfunction

    function automatic int c_x(input int k); return (k <= 7) ? 316 - 2*k : 288 + 2*k; endfunction

    initial begin
        tbl[0] = '{10'd316, 10'd236, 1'b1};
        tbl[1] = '{10'd323, 10'd243, 1'b1};
        tbl[2] = '{10'd320, 10'd240, 1'b1};
        tbl[3] = '{10'd315, 10'd240, 1'b0};
        tbl[4] = '{10'd324, 10'd240, 1'b0};
        tbl[5] = '{10'd320, 10'd235, 1'b0};
        tbl[6] = '{10'd320, 10'd244, 1'b0};
        tbl[7] = '{10'd323, 10'd236, 1'b1};
        tbl[8] = '{10'd316, 10'd243, 1'b1};
        tbl[9] = '{10'd0,   10'd0,   1'b0};

        x = '0; y = '0;
        pads_far();

        // A: reset, ball_on table, serve, leftward run into a left miss.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            x = tbl[i].px;
            y = tbl[i].py;
            #1;
            chk($sformatf("ball_on[%0d]", i), ball_on, tbl[i].on);
        end
        y = '0;
        serve();
        for (int k = 1; k <= 157; k++) begin
            tick();
            chk($sformatf("A_x[%0d]", k), ball_x, a_x(k));
            chk($sformatf("A_y[%0d]", k), ball_y, a_y(k));
            chk($sformatf("A_miss2[%0d]", k), miss2, 0);
        end
        tick();
        chk("A_miss2_pulse", miss2, 1);
        chk("A_miss1_quiet", miss1, 0);
        chk("A_no_move_x", ball_x, 2);
        chk("A_in_miss", serving, 0);
        idle();
        chk("A_miss2_cleared", miss2, 0);
        tick();
        chk("A_recentre_x", ball_x, 316);
        chk("A_recentre_y", ball_y, 236);
        chk("A_serving", serving, 1);
        chk("A_miss2_after", miss2, 0);

        // B: paddle and wall bounces, then asynchronous reset mid-rally.
        do_reset();
        pad2_t = 10'd0;   pad2_b = 10'd479; pad2_l = 10'd300; pad2_r = 10'd303;
        pad1_t = 10'd380; pad1_b = 10'd451; pad1_l = 10'd600; pad1_r = 10'd603;
        serve();
        for (int k = 1; k <= 360; k++) begin
            tick();
            chk($sformatf("B_x[%0d]", k), ball_x, b_x(k));
            chk($sformatf("B_y[%0d]", k), ball_y, b_y(k));
            chk($sformatf("B_miss1[%0d]", k), miss1, 0);
            chk($sformatf("B_miss2[%0d]", k), miss2, 0);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // C: left paddle sends ball right into a right miss; next serve goes right.
        pad1_t = 10'd1000; pad1_b = 10'd1010; pad1_l = 10'd1000; pad1_r = 10'd1010;
        serve();
        for (int k = 1; k <= 171; k++) begin
            tick();
            chk($sformatf("C_x[%0d]", k), ball_x, c_x(k));
            chk($sformatf("C_miss1[%0d]", k), miss1, 0);
        end
        chk("C_y_end", ball_y, 362);
        tick();
        chk("C_miss1_pulse", miss1, 1);
        chk("C_miss2_quiet", miss2, 0);
        chk("C_no_move_x", ball_x, 630);
        idle();
        chk("C_miss1_cleared", miss1, 0);
        tick();
        chk("C_serving", serving, 1);
        chk("C_recentre_x", ball_x, 316);
        serve();
        tick();
        chk("C_serve_move_x", ball_x, 318);
        chk("C_serve_move_y", ball_y, 234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
